// File: rtl/uart_echo_responder_if.sv
// Serial and status bundle for the UART echo responder.
// The slave view belongs to the responder, the master view to whoever drives the line.
interface uart_echo_responder_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               i_Rx_Serial;
    logic               o_Tx_Serial;
    logic               o_Tx_Active;
    logic [7:0]         o_Rx_Byte;
    logic               o_Rx_DV;
    logic               o_Frame_Err;
    logic               o_Overflow;
    logic [COUNT_W-1:0] o_Fifo_Count;

    modport slave (
        input  i_Rx_Serial,
        output o_Tx_Serial, o_Tx_Active, o_Rx_Byte, o_Rx_DV,
               o_Frame_Err, o_Overflow, o_Fifo_Count
    );

    modport master (
        output i_Rx_Serial,
        input  o_Tx_Serial, o_Tx_Active, o_Rx_Byte, o_Rx_DV,
               o_Frame_Err, o_Overflow, o_Fifo_Count
    );
endinterface

// File: rtl/uart_echo_responder.sv
// Far-end UART loopback peer: receives 8N1 frames, queues good bytes in a
// small FIFO and re-transmits them unchanged. Sticky error flags and the
// last good byte are exposed for display.
module uart_echo_responder #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    uart_echo_responder_if.slave  bus
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]   BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(FIFO_DEPTH);
    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    // Receiver state
    logic             rx_meta_q, rx_sync_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_dv_q, rx_dv_d;
    logic             frame_err_q, frame_err_d;

    // Echo FIFO state
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [7:0]         fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] fifo_count_q, fifo_count_d;
    logic               overflow_q, overflow_d;

    // Transmitter state
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_serial, tx_active;

    logic rx_half, rx_tick, tx_tick;
    logic fifo_push, fifo_pop, fifo_full, push_ok;

    assign rx_half   = (rx_cnt_q == HALF_LAST);
    assign rx_tick   = (rx_cnt_q == BIT_LAST);
    assign tx_tick   = (tx_cnt_q == BIT_LAST);
    assign fifo_push = rx_dv_q;
    assign fifo_full = (fifo_count_q == COUNT_MAX);
    assign fifo_pop  = (tx_state_q == TX_IDLE) && (fifo_count_q != '0);
    assign push_ok   = fifo_push && (!fifo_full || fifo_pop);

    // Register every control/status flop; reset returns both FSMs to idle.
    always_ff @(posedge i_Clock) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values, independent of statement order.
        if (i_Reset) begin
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_byte_q    <= '0;
            rx_dv_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            overflow_q   <= 1'b0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
        end else begin
            rx_meta_q    <= bus.i_Rx_Serial;
            rx_sync_q    <= rx_meta_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_byte_q    <= rx_byte_d;
            rx_dv_q      <= rx_dv_d;
            frame_err_q  <= frame_err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            overflow_q   <= overflow_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
        end
    end

    // FIFO storage: data only, validity is tracked by the pointers and count.
    always_ff @(posedge i_Clock) begin
        // NOTE: storage is deliberately not reset; stale entries are never read because the count gates every pop.
        fifo_mem_q <= fifo_mem_d;
    end

    // RX next state: start qualification, 8 data samples, stop sample, one cleanup cycle.
    always_comb begin
        // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:    if (!rx_sync_q) rx_state_d = RX_START;
            RX_START:   if (rx_half) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:    if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:    if (rx_tick) rx_state_d = RX_CLEANUP;
            RX_CLEANUP: rx_state_d = RX_IDLE;
            default:    rx_state_d = RX_IDLE;
        endcase
    end

    // RX datapath: bit timing, shift register, byte capture and frame error.
    always_comb begin
        rx_cnt_d    = rx_cnt_q + CNT_ONE;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
        frame_err_d = frame_err_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            RX_START: if (rx_half) rx_cnt_d = '0;
            RX_DATA: if (rx_tick) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
            end
            RX_STOP: if (rx_tick) begin
                rx_cnt_d = '0;
                if (rx_sync_q) begin
                    rx_byte_d = rx_shift_q;
                    rx_dv_d   = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            RX_CLEANUP: rx_cnt_d = '0;
            default:    rx_cnt_d = '0;
        endcase
    end

    // FIFO update: a push into a full FIFO only succeeds when a pop frees the slot that cycle.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q | (fifo_push && !push_ok);
        if (push_ok) begin
            fifo_mem_d[wr_ptr_q] = rx_byte_q;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end
        if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push_ok, fifo_pop})
            2'b10:   fifo_count_d = fifo_count_q + COUNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - COUNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    // TX next state: leave idle whenever a byte is queued, then walk start/data/stop.
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:  if (fifo_pop) tx_state_d = TX_START;
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_d = TX_IDLE;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX datapath: load the FIFO head on pop, shift LSB first once per bit period.
    always_comb begin
        tx_cnt_d   = tx_cnt_q + CNT_ONE;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                tx_bit_d = '0;
                if (fifo_pop) tx_shift_d = fifo_mem_q[rd_ptr_q];
            end
            TX_START: if (tx_tick) tx_cnt_d = '0;
            TX_DATA: if (tx_tick) begin
                tx_cnt_d   = '0;
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 3'd1;
            end
            TX_STOP: if (tx_tick) tx_cnt_d = '0;
            default: tx_cnt_d = '0;
        endcase
    end

    // TX outputs decoded from state so the line is high in the first cycle after reset.
    always_comb begin
        tx_active = (tx_state_q != TX_IDLE);
        unique case (tx_state_q)
            TX_START: tx_serial = 1'b0;
            TX_DATA:  tx_serial = tx_shift_q[0];
            default:  tx_serial = 1'b1;
        endcase
    end

    assign bus.o_Tx_Serial  = tx_serial;
    assign bus.o_Tx_Active  = tx_active;
    assign bus.o_Rx_Byte    = rx_byte_q;
    assign bus.o_Rx_DV      = rx_dv_q;
    assign bus.o_Frame_Err  = frame_err_q;
    assign bus.o_Overflow   = overflow_q;
    assign bus.o_Fifo_Count = fifo_count_q;
endmodule

// File: doc/uart_echo_responder.md
# uart_echo_responder

Far-end UART responder for the serial link driven by our transmitter/receiver pair. It deserialises 8N1 frames from `i_Rx_Serial` and stores good bytes in a small FIFO. It then re-serialises them unchanged on `o_Tx_Serial`, acting as the loopback peer for board-to-board link tests. It also exposes the last received byte and the error flags so they can be shown on the seven-segment displays.

## Interface
- `CLKS_PER_BIT`, 5208: clock cycles per serial bit, same for RX and TX; must be ≥ 4.
- `FIFO_DEPTH`, 4: echo buffer entries; must be a power of two, ≥ 2.
- `i_Clock` in 1: single system clock; all logic is on its rising edge.
- `i_Reset` in 1: synchronous, active-high reset.
- `i_Rx_Serial` in 1: asynchronous serial input, idle high.
- `o_Tx_Serial` out 1: serial echo output, idle high.
- `o_Tx_Active` out 1: high while an echo frame is on the line.
- `o_Rx_Byte` out 8: last correctly framed byte; holds until the next good byte.
- `o_Rx_DV` out 1: one-cycle pulse when `o_Rx_Byte` updates.
- `o_Frame_Err` out 1: sticky; set when a stop bit is sampled low.
- `o_Overflow` out 1: sticky; set when a good byte arrives while the FIFO is full.
- `o_Fifo_Count` out $clog2(FIFO_DEPTH)+1: number of bytes currently queued.

## Operation
- `i_Rx_Serial` passes through a 2-flop synchroniser. All RX decisions use the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE → START on a low synchronised input.
  - In START, wait CLKS_PER_BIT/2 cycles (integer division), then sample. If low, go to DATA. If high, treat it as a glitch and return to IDLE with no flags set.
  - DATA takes 8 samples, one every CLKS_PER_BIT cycles, LSB first.
  - STOP samples once after a further CLKS_PER_BIT cycles. If high, the byte is good: update `o_Rx_Byte`, pulse `o_Rx_DV`, and push it to the FIFO. If low, set `o_Frame_Err`; the byte is discarded and there is no DV and no push.
  - CLEANUP lasts 1 cycle, then the FSM returns to IDLE.
- FIFO behaviour:
  - A push while full is dropped, sets `o_Overflow`, and leaves the FIFO contents unchanged.
  - A push and a pop in the same cycle are both performed and the count is unchanged. This also applies when full: the push is accepted and no overflow is flagged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE with the FIFO non-empty, pop the head into the shift register and go to START.
  - START drives 0, DATA drives the 8 bits LSB first, STOP drives 1. Each bit lasts exactly CLKS_PER_BIT cycles.
  - After STOP, return to IDLE. A queued byte pops on that IDLE cycle, so back-to-back frames have 1 idle-high cycle between them.
- Sticky flags clear only on `i_Reset`.

## Timing
- Reset values:
  - `o_Tx_Serial` = 1
  - `o_Tx_Active` = 0
  - `o_Rx_Byte` = 8'h00
  - `o_Rx_DV` = 0
  - `o_Frame_Err` = 0
  - `o_Overflow` = 0
  - `o_Fifo_Count` = 0
  - FIFO pointers = 0
  - both FSMs = IDLE
- Reset mid-frame abandons both RX and TX frames. The line is high from the first cycle after reset.
- RX timing:
  - The start-bit midpoint sample occurs CLKS_PER_BIT/2 cycles after the synchronised falling edge.
  - Data and stop bits are sampled at intervals of CLKS_PER_BIT after that midpoint.
  - `o_Rx_DV` is registered high in the cycle after the stop sample.
  - The FIFO write takes effect at the end of the DV cycle.
- Echo latency: with DV high in cycle N and the TX FSM idle, the pop occurs in N+1 and `o_Tx_Serial` goes low in N+2.
- `o_Tx_Active` rises with the start bit and falls with the first IDLE cycle after the stop bit. One frame occupies 10·CLKS_PER_BIT cycles of `o_Tx_Active`.
- `o_Fifo_Count` updates one cycle after a push or pop.
- A new start edge is accepted the cycle after CLEANUP. Frames arriving at full line rate are not lost while the FIFO has space.

## Test plan
All scenarios use CLKS_PER_BIT=8 and FIFO_DEPTH=4.
- Reset, then idle for 200 cycles → `o_Tx_Serial`=1, all other outputs at their reset values, no DV pulse.
- Send frame 8'hA5 → exactly one `o_Rx_DV` pulse with `o_Rx_Byte`=8'hA5. `o_Tx_Serial` falls 2 cycles after DV, and the echoed frame decodes to 8'hA5 over 80 cycles of `o_Tx_Active`.
- Send 8'h3C with the stop bit held low → `o_Frame_Err`=1, no DV, no echo, `o_Rx_Byte` unchanged, `o_Fifo_Count`=0.
- Send 6 back-to-back frames 8'h01 to 8'h06 → 6 DV pulses and `o_Fifo_Count` never exceeds 4. Check whether `o_Overflow` sets against a reference model of the drain timing; every accepted byte is echoed in order.
- Send a 3-cycle low glitch on `i_Rx_Serial` → no DV, no error flags, RX returns to IDLE.
- Assert `i_Reset` mid-echo of 8'hFF → next cycle `o_Tx_Serial`=1, `o_Tx_Active`=0, `o_Fifo_Count`=0; a following 8'h5A frame echoes correctly.
